arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 105 ++++++++++
 tb/tb_arb_mux.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready arbiter feeding one registered output word.
// The arbitration mode is selectable: forced select, fixed priority or round-robin.
module arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_grant,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] PTR_RST = SELW'(NCH - 1);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_vld;
    logic [WIDTH-1:0] gnt_data;
    logic             free;
    logic             xfer;
    int               rr_idx;

    // Grant decision for this cycle from the request vector, mode, sel and pointer
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        case (mode)
            2'b00: begin
                // sel values beyond the last channel never match, so nothing is granted
                for (int i = 0; i < int'(NCH); i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            2'b01: begin
                // Scan downwards so the lowest requesting index is the last one written
                for (int i = int'(NCH) - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            default: begin
                // Scan from the farthest offset back to ptr+1 so the nearest requester wins
                for (int k = int'(NCH); k >= 1; k--) begin
                    rr_idx = (int'(ptr) + k) % int'(NCH);
                    if (in_valid[SELW'(rr_idx)]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(rr_idx);
                    end
                end
            end
        endcase
    end

    // Word of the granted channel
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Handshake: one-hot ready toward the granted channel when the output register can take a word
    always_comb begin
        free = !out_valid || out_ready;
        in_ready = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            in_ready[i] = !rst && free && gnt_vld && (gnt_idx == SELW'(i));
        end
        xfer = |in_ready;
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            ptr       <= PTR_RST;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_grant <= gnt_idx;
            ptr       <= gnt_idx;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: constant vector table, directed corner sequences and a
// randomized run checked against a behavioural model of the arbitration rules.
module tb_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic          rst4;
    logic [N*W-1:0] in_data4;
    logic [N-1:0]  in_valid4;
    logic [N-1:0]  in_ready4;
    logic [1:0]    mode4;
    logic [1:0]    sel4;
    logic [W-1:0]  out_data4;
    logic          out_valid4;
    logic [1:0]    out_grant4;
    logic          out_ready4;

    // 3-channel instance for the out-of-range select case
    logic          rst3;
    logic [3*W-1:0] in_data3;
    logic [2:0]    in_valid3;
    logic [2:0]    in_ready3;
    logic [1:0]    mode3;
    logic [1:0]    sel3;
    logic [W-1:0]  out_data3;
    logic          out_valid3;
    logic [1:0]    out_grant3;
    logic          out_ready3;

    arb_mux #(.WIDTH(W), .NCH(N), .SELW(2)) dut4 (
        .clk(clk), .rst(rst4), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
        .out_valid(out_valid4), .out_grant(out_grant4), .out_ready(out_ready4)
    );

    arb_mux #(.WIDTH(W), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_valid(out_valid3), .out_grant(out_grant3), .out_ready(out_ready3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] chd [N];

    typedef struct {
        logic        r;
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_og;
        logic [31:0] e_od;
    } vec_t;

    vec_t tbl [10];

    // behavioural model state
    bit          m_valid;
    logic [31:0] m_data;
    int          m_grant;
    int          m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack4();
        for (int i = 0; i < N; i++) in_data4[i*W +: W] = chd[i];
    endtask

    // Arbitration rule applied directly: which channel should be served this cycle
    function automatic void model_grant(input int md, input int s, input int v, input int p,
                                        output bit ok, output int idx);
        ok  = 1'b0;
        idx = 0;
        if (md == 0) begin
            if (s < N && ((v >> s) & 1) == 1) begin
                ok  = 1'b1;
                idx = s;
            end
        end else if (md == 1) begin
            for (int i = 0; i < N; i++) begin
                if (!ok && ((v >> i) & 1) == 1) begin
                    ok  = 1'b1;
                    idx = i;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (p + k) % N;
                if (!ok && ((v >> c) & 1) == 1) begin
                    ok  = 1'b1;
                    idx = c;
                end
            end
        end
    endfunction

    initial begin
        bit ok;
        int idx;
        int er;
        int ri;

        for (int i = 0; i < N; i++) chd[i] = 32'hCAFE0000 + 32'(i);
        pack4();
        rst4 = 1'b1; in_valid4 = '0; mode4 = 2'b00; sel4 = '0; out_ready4 = 1'b0;
        rst3 = 1'b1; in_valid3 = '0; mode3 = 2'b00; sel3 = '0; out_ready3 = 1'b0;
        in_data3 = {32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000};

        // reset state
        in_valid4 = 4'hF; out_ready4 = 1'b1; mode4 = 2'b01;
        tick();
        #1 chk("rst_in_ready", 32'(in_ready4), 32'h0);
        tick();
        chk("rst_out_valid", 32'(out_valid4), 32'h0);
        chk("rst_out_data", out_data4, 32'h0);
        chk("rst_out_grant", 32'(out_grant4), 32'h0);

        // vector table, applied in order starting from reset state (pointer = 3)
        tbl[0] = '{1'b0, 2'b00, 2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 32'hCAFE0002};
        tbl[1] = '{1'b0, 2'b01, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hCAFE0001};
        tbl[2] = '{1'b0, 2'b01, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hCAFE0001};
        tbl[3] = '{1'b0, 2'b01, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hCAFE0001};
        tbl[4] = '{1'b0, 2'b10, 2'd0, 4'hF,    1'b0, 4'b0100, 1'b1, 2'd2, 32'hCAFE0002};
        tbl[5] = '{1'b0, 2'b10, 2'd0, 4'hF,    1'b0, 4'b0000, 1'b1, 2'd2, 32'hCAFE0002};
        tbl[6] = '{1'b0, 2'b11, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hCAFE0003};
        tbl[7] = '{1'b0, 2'b00, 2'd0, 4'b1110, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hCAFE0003};
        tbl[8] = '{1'b0, 2'b00, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hCAFE0001};
        tbl[9] = '{1'b1, 2'b01, 2'd0, 4'hF,    1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};

        for (int v = 0; v < 10; v++) begin
            rst4 = tbl[v].r; mode4 = tbl[v].mode; sel4 = tbl[v].sel;
            in_valid4 = tbl[v].vld; out_ready4 = tbl[v].ordy;
            #1 chk($sformatf("vec%0d_in_ready", v), 32'(in_ready4), 32'(tbl[v].e_rdy));
            tick();
            chk($sformatf("vec%0d_out_valid", v), 32'(out_valid4), 32'(tbl[v].e_ov));
            chk($sformatf("vec%0d_out_grant", v), 32'(out_grant4), 32'(tbl[v].e_og));
            chk($sformatf("vec%0d_out_data", v), out_data4, tbl[v].e_od);
        end

        // round-robin sweep from reset pointer: 0,1,2,3,0,1,2,3
        rst4 = 1'b0; mode4 = 2'b10; in_valid4 = 4'hF; out_ready4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("rr%0d_in_ready", k), 32'(in_ready4), 32'(1 << (k % 4)));
            tick();
            chk($sformatf("rr%0d_out_grant", k), 32'(out_grant4), 32'(k % 4));
            chk($sformatf("rr%0d_out_valid", k), 32'(out_valid4), 32'h1);
            chk($sformatf("rr%0d_out_data", k), out_data4, 32'hCAFE0000 + 32'(k % 4));
        end

        // backpressure: hold ch0 word for 3 cycles, then drain with same-cycle refill
        mode4 = 2'b01; in_valid4 = 4'b0001; out_ready4 = 1'b1;
        #1 chk("bp_load_in_ready", 32'(in_ready4), 32'h1);
        tick();
        out_ready4 = 1'b0;
        chd[0] = 32'h12345678; pack4();
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp%0d_in_ready", k), 32'(in_ready4), 32'h0);
            tick();
            chk($sformatf("bp%0d_out_data", k), out_data4, 32'hCAFE0000);
            chk($sformatf("bp%0d_out_valid", k), 32'(out_valid4), 32'h1);
        end
        out_ready4 = 1'b1;
        #1 chk("bp_release_in_ready", 32'(in_ready4), 32'h1);
        tick();
        chk("bp_release_out_data", out_data4, 32'h12345678);
        chk("bp_release_out_valid", 32'(out_valid4), 32'h1);

        // reset with a word held under backpressure
        out_ready4 = 1'b0; rst4 = 1'b1;
        #1 chk("midrst_in_ready", 32'(in_ready4), 32'h0);
        tick();
        chk("midrst_out_valid", 32'(out_valid4), 32'h0);
        chk("midrst_out_data", out_data4, 32'h0);
        chk("midrst_out_grant", 32'(out_grant4), 32'h0);
        rst4 = 1'b0; mode4 = 2'b10; in_valid4 = 4'hF; out_ready4 = 1'b1;
        #1 chk("postrst_in_ready", 32'(in_ready4), 32'h1);
        tick();
        chk("postrst_out_grant", 32'(out_grant4), 32'h0);
        chk("postrst_out_data", out_data4, 32'h12345678);
        in_valid4 = '0;

        // 3-channel instance: sel beyond last channel grants nothing
        rst3 = 1'b0; mode3 = 2'b01; in_valid3 = 3'b111; out_ready3 = 1'b0;
        #1 chk("n3_load_in_ready", 32'(in_ready3), 32'h1);
        tick();
        chk("n3_load_out_valid", 32'(out_valid3), 32'h1);
        chk("n3_load_out_data", out_data3, 32'hBEEF0000);
        mode3 = 2'b00; sel3 = 2'd3;
        for (int k = 0; k < 2; k++) begin
            #1 chk($sformatf("n3_hold%0d_in_ready", k), 32'(in_ready3), 32'h0);
            tick();
            chk($sformatf("n3_hold%0d_out_valid", k), 32'(out_valid3), 32'h1);
        end
        out_ready3 = 1'b1;
        #1 chk("n3_drain_in_ready", 32'(in_ready3), 32'h0);
        tick();
        chk("n3_drain_out_valid", 32'(out_valid3), 32'h0);
        sel3 = 2'd2;
        #1 chk("n3_sel2_in_ready", 32'(in_ready3), 32'h4);
        tick();
        chk("n3_sel2_out_grant", 32'(out_grant3), 32'h2);
        chk("n3_sel2_out_data", out_data3, 32'hBEEF0002);

        // randomized run against the model
        rst4 = 1'b1; in_valid4 = '0;
        tick();
        m_valid = 1'b0; m_data = '0; m_grant = 0; m_ptr = N - 1;
        for (int c = 0; c < 400; c++) begin
            rst4       = ($urandom_range(0, 39) == 0);
            mode4      = 2'($urandom_range(0, 3));
            sel4       = 2'($urandom_range(0, 3));
            in_valid4  = 4'($urandom_range(0, 15));
            out_ready4 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) chd[i] = $urandom;
            pack4();
            model_grant(int'(mode4), int'(sel4), int'(in_valid4), m_ptr, ok, idx);
            er = (!rst4 && (!m_valid || out_ready4) && ok) ? (1 << idx) : 0;
            #1 chk("rand_in_ready", 32'(in_ready4), 32'(er));
            tick();
            if (rst4) begin
                m_valid = 1'b0; m_data = '0; m_grant = 0; m_ptr = N - 1;
            end else if (er != 0) begin
                m_valid = 1'b1; m_data = chd[idx]; m_grant = idx; m_ptr = idx;
            end else if (!m_valid || out_ready4) begin
                m_valid = 1'b0;
            end
            ri = c;
            chk($sformatf("rand%0d_out_valid", ri), 32'(out_valid4), 32'(m_valid));
            chk($sformatf("rand%0d_out_grant", ri), 32'(out_grant4), 32'(m_grant));
            chk($sformatf("rand%0d_out_data", ri), out_data4, m_data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
